// File: rtl/sdram_burst_reader.sv
// Streams a burst of sequential SDRAM reads: issues read commands into the controller FIFO,
// captures the un-throttled return path into a local buffer and replays it as a valid/ready stream.
module sdram_burst_reader #(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] base_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cmd_write,
  input  logic        cmd_full,
  output logic        cmd_is_write,
  output logic [24:0] cmd_address,
  output logic [1:0]  cmd_write_mask,
  output logic [15:0] cmd_write_data,
  input  logic        rd_valid,
  input  logic [24:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t        state_q, state_d;
  logic [24:0]   base_q, base_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d;
  logic [15:0]   pop_cnt_q, pop_cnt_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          err_q, err_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [15:0]   mem_q [DEPTH];

  logic        issue, pop, push, rx_open, empty, full;
  logic [24:0] exp_addr;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign out_valid = ~empty;
  assign out_data  = empty ? 16'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign out_last  = ~empty && (pop_cnt_q == len_q - 16'd1);
  assign pop       = out_valid & out_ready;

  // Credits bound reads in flight plus buffered words, so the return path can never overflow.
  assign cmd_write      = (state_q == ISSUE) && !cmd_full && (credits_q < CW'(DEPTH));
  assign issue          = cmd_write;
  assign cmd_address    = base_q + 25'(issue_cnt_q);
  assign cmd_is_write   = 1'b0;
  assign cmd_write_mask = 2'b11;
  assign cmd_write_data = 16'd0;

  assign exp_addr = base_q + 25'(rx_cnt_q);
  assign rx_open  = ((state_q == ISSUE) || (state_q == DRAIN)) && (rx_cnt_q != len_q);
  assign push     = rd_valid & rx_open;

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
  assign err  = err_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    err_d       = err_q;
    credits_d   = credits_q + CW'(issue) - CW'(pop);
    if (issue) issue_cnt_d = issue_cnt_q + 16'd1;
    if (push)  rx_cnt_d    = rx_cnt_q + 16'd1;
    if (pop)   pop_cnt_d   = pop_cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = length;
          issue_cnt_d = 16'd0;
          rx_cnt_d    = 16'd0;
          pop_cnt_d   = 16'd0;
          err_d       = 1'b0;
          state_d     = (length != 16'd0) ? ISSUE : FIN;
        end
      end
      ISSUE: begin
        if (issue && (issue_cnt_d == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((rx_cnt_q == len_q) && (pop_cnt_q == len_q)) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Unexpected or misaddressed returns set the sticky flag; misaddressed words are still kept.
    if (rd_valid && (!rx_open || (rd_addr != exp_addr))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      pop_cnt_q   <= '0;
      credits_q   <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rd_data;
  end

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Scoreboard bench: a memory-model responder returns reads with fixed latency, monitors compare
// command addresses and stream words against queues filled by the directed stimulus.
module tb_sdram_burst_reader;
  localparam int DEPTH = 16;
  localparam int LAT   = 5;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [24:0] base_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, err, cmd_write, cmd_is_write, out_valid, out_last;
  logic        cmd_full = 1'b0, out_ready = 1'b0;
  logic [24:0] cmd_address;
  logic [1:0]  cmd_write_mask;
  logic [15:0] cmd_write_data, out_data;
  logic        rd_valid = 1'b0;
  logic [24:0] rd_addr = '0;
  logic [15:0] rd_data = '0;

  int checks = 0, failures = 0, cyc = 0;
  int cmd_cnt = 0, done_cnt = 0, inject_req = 0, inject_ack = 0;
  logic        corrupt_en = 1'b0;
  logic [24:0] corrupt_addr = '0;
  logic [24:0] exp_cmd_q [$];
  logic [16:0] exp_out_q [$];
  logic [24:0] pend_addr [$];
  int          pend_due [$];
  int          cmd_cyc_log [$];
  logic        hold_v = 1'b0;
  logic [16:0] hold_w = '0, mon_w;
  logic [24:0] ret_a;
  int          ret_d;

  sdram_burst_reader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err),
    .cmd_write(cmd_write), .cmd_full(cmd_full), .cmd_is_write(cmd_is_write),
    .cmd_address(cmd_address), .cmd_write_mask(cmd_write_mask), .cmd_write_data(cmd_write_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #1000000; $display("FAIL watchdog simulation time limit"); $fatal(1); end

  function automatic logic [15:0] mem_word(input logic [24:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {7'd0, a[24:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    failures++;
    $display("FAIL %s %s", name, detail);
  endtask

  // Monitor + responder: sampled at negedge, so handshakes seen here complete at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        hold_v = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (hold_v) begin
          check("out_hold_valid", out_valid, 1);
          check("out_hold_word", {out_last, out_data}, hold_w);
        end
        if (cmd_write) begin
          check("cmd_while_full", cmd_full, 0);
          check("cmd_fixed_fields", {cmd_is_write, cmd_write_mask, cmd_write_data}, 19'h30000);
          if (exp_cmd_q.size() == 0) fail("cmd_unexpected", $sformatf("actual addr=%0h required none", cmd_address));
          else check("cmd_address", cmd_address, exp_cmd_q.pop_front());
          cmd_cnt++;
          cmd_cyc_log.push_back(cyc);
          pend_addr.push_back(cmd_address);
          pend_due.push_back(cyc + LAT);
        end
        if (out_valid && out_ready) begin
          if (exp_out_q.size() == 0) fail("out_unexpected", $sformatf("actual data=%0h required none", out_data));
          else begin
            mon_w = exp_out_q.pop_front();
            check("out_data", out_data, mon_w[15:0]);
            check("out_last", out_last, mon_w[16]);
          end
        end
        hold_v = out_valid && !out_ready;
        hold_w = {out_last, out_data};
        if (inject_req != inject_ack) begin
          inject_ack = inject_req;
          rd_valid = 1'b1;
          rd_addr  = 25'h0ABCDE;
          rd_data  = 16'hDEAD;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          ret_a = pend_addr.pop_front();
          ret_d = pend_due.pop_front();
          rd_valid = 1'b1;
          rd_addr  = (corrupt_en && ret_a == corrupt_addr) ? ret_a + 25'd1 : ret_a;
          rd_data  = mem_word(ret_a);
        end
        #1;
        checks++;
        assert (!(dut.push && dut.full)) else begin
          failures++;
          $display("FAIL buffer_overflow actual push into full buffer required none at cycle %0d", cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [24:0] a, input logic last);
    exp_cmd_q.push_back(a);
    exp_out_q.push_back({last, mem_word(a)});
  endtask

  task automatic expect_seq(input logic [24:0] base, input int len);
    for (int i = 0; i < len; i++) expect_word(base + 25'(i), i == len - 1);
  endtask

  task automatic start_burst(input logic [24:0] b, input logic [15:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin tick(1); n++; end
    if (n >= 3000) fail(name, "actual no done within 3000 cycles required done");
  endtask

  task automatic end_burst(input string name, input int c0, input int d0, input int ncmd);
    tick(3);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_cmd_count"}, cmd_cnt - c0, ncmd);
    check({name, "_cmd_q_empty"}, exp_cmd_q.size(), 0);
    check({name, "_out_q_empty"}, exp_out_q.size(), 0);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, {busy, done, err, cmd_write, out_valid, out_last}, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_cmd_address"}, cmd_address, 0);
  endtask

  int c0, d0, c1;

  initial begin
    // Reset
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    tick(1);
    check_reset_outputs("reset_released");

    // Basic burst
    out_ready = 1'b1;
    c0 = cmd_cnt; d0 = done_cnt;
    expect_seq(25'h400, 8);
    start_burst(25'h400, 16'd8);
    check("basic_busy", busy, 1);
    wait_done("basic_timeout", d0);
    end_burst("basic", c0, d0, 8);
    if (cmd_cyc_log.size() >= c0 + 8) check("basic_cmd_consecutive", cmd_cyc_log[c0 + 7] - cmd_cyc_log[c0], 7);
    check("basic_err", err, 0);

    // Credit stall
    out_ready = 1'b0;
    c0 = cmd_cnt; d0 = done_cnt;
    expect_seq(25'h10000, 40);
    start_burst(25'h10000, 16'd40);
    tick(40);
    check("stall_cmd_count", cmd_cnt - c0, DEPTH);
    check("stall_cmd_write", cmd_write, 0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_done("stall_timeout", d0);
    end_burst("stall", c0, d0, 40);

    // Command FIFO full mid-burst
    c0 = cmd_cnt; d0 = done_cnt;
    expect_seq(25'h0123456, 30);
    start_burst(25'h0123456, 16'd30);
    tick(5);
    cmd_full = 1'b1;
    c1 = cmd_cnt;
    tick(10);
    check("full_no_cmd", cmd_cnt - c1, 0);
    cmd_full = 1'b0;
    wait_done("full_timeout", d0);
    end_burst("full", c0, d0, 30);

    // Address wrap
    c0 = cmd_cnt; d0 = done_cnt;
    expect_word(25'h1FFFFFE, 1'b0);
    expect_word(25'h1FFFFFF, 1'b0);
    expect_word(25'h0000000, 1'b0);
    expect_word(25'h0000001, 1'b1);
    start_burst(25'h1FFFFFE, 16'd4);
    wait_done("wrap_timeout", d0);
    end_burst("wrap", c0, d0, 4);

    // Zero length
    c0 = cmd_cnt; d0 = done_cnt;
    start_burst(25'h55, 16'd0);
    check("zero_done_next", {done, busy}, 2'b11);
    tick(1);
    check("zero_done_pulse", {done, busy}, 2'b00);
    end_burst("zero", c0, d0, 0);

    // Misaddressed return on word 3
    c0 = cmd_cnt; d0 = done_cnt;
    corrupt_en = 1'b1;
    corrupt_addr = 25'h803;
    expect_seq(25'h800, 8);
    start_burst(25'h800, 16'd8);
    wait_done("badaddr_timeout", d0);
    end_burst("badaddr", c0, d0, 8);
    check("badaddr_err", err, 1);
    corrupt_en = 1'b0;
    tick(5);
    check("badaddr_err_sticky", err, 1);
    d0 = done_cnt;
    start_burst(25'h0, 16'd0);
    check("start_clears_err", err, 0);
    tick(3);

    // Extra return after the burst
    c0 = cmd_cnt; d0 = done_cnt;
    expect_seq(25'h900, 4);
    start_burst(25'h900, 16'd4);
    wait_done("extra_timeout", d0);
    end_burst("extra", c0, d0, 4);
    check("extra_err_before", err, 0);
    inject_req++;
    tick(4);
    check("extra_err", err, 1);
    check("extra_dropped", out_valid, 0);

    // Reset during ISSUE
    d0 = done_cnt;
    expect_seq(25'hA00, 30);
    start_burst(25'hA00, 16'd30);
    tick(6);
    check("midrst_busy", busy, 1);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midrst_held");
    rst = 1'b0;
    exp_cmd_q.delete();
    exp_out_q.delete();
    tick(10);
    check_reset_outputs("midrst_after");
    check("midrst_no_done", done_cnt - d0, 0);

    // Recovery burst after reset
    c0 = cmd_cnt; d0 = done_cnt;
    expect_seq(25'h20, 3);
    start_burst(25'h20, 16'd3);
    wait_done("recover_timeout", d0);
    end_burst("recover", c0, d0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
